// File: rtl/linalg_pkg.sv
// linalg_pkg: shared definitions for the linear-algebra block family.
//   WORD_W  - width of one matrix element
//   state_t - two-state handshake FSM used by the matrix serializer
//   idx_w() - index width for a count of n items (clog2, never below 1)
package linalg_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    GET_MAT   = 1'b0,
    PUT_WORDS = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mat_serializer.sv
// mat_serializer: captures a whole M x P matrix on a matrix-level stb/ack
// handshake and replays it one element per transfer on a word-level stb/ack
// stream, tagged with its emission index and a last flag.
//
// Ports
//   clk              clock, all state on the rising edge
//   rst              asynchronous, active-low reset
//   input_mat        matrix, element (r,c) = input_mat[r][c]
//   input_mat_stb    producer offers input_mat
//   input_mat_ack    block ready to capture a matrix (registered)
//   output_word      current element (registered)
//   output_index     emission index k of output_word (registered)
//   output_last      high while output_word is element k = M*P-1 (registered)
//   output_word_stb  output_word/index/last valid (registered)
//   output_word_ack  sink accepts the current word
//
// COL_MAJOR = 0 emits row-major (k = r*P + c), 1 emits column-major
// (k = c*M + r). Order comes purely from how the r/c counters nest.
module mat_serializer
  import linalg_pkg::*;
#(
  parameter int M         = 1,
  parameter int P         = 1,
  parameter bit COL_MAJOR = 1'b0,
  parameter int IDX_W     = idx_w(M * P)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [M-1:0][P-1:0][WORD_W-1:0]   input_mat,
  input  logic                              input_mat_stb,
  output logic                              input_mat_ack,
  output logic [WORD_W-1:0]                 output_word,
  output logic [IDX_W-1:0]                  output_index,
  output logic                              output_last,
  output logic                              output_word_stb,
  input  logic                              output_word_ack
);

  localparam int RW = idx_w(M);
  localparam int CW = idx_w(P);
  localparam logic [RW-1:0]    R_LAST = RW'(M - 1);
  localparam logic [CW-1:0]    C_LAST = CW'(P - 1);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(M * P - 1);

  state_t                            state_q, state_d;
  logic [M-1:0][P-1:0][WORD_W-1:0]   buf_q, buf_d;
  logic [RW-1:0]                     r_q, r_d, r_step;
  logic [CW-1:0]                     c_q, c_d, c_step;
  logic [IDX_W-1:0]                  k_q, k_d, k_step;
  logic [WORD_W-1:0]                 word_q, word_d, sel_word;
  logic                              last_q, last_d;
  logic                              stb_q, stb_d;
  logic                              mat_ack_q, mat_ack_d;

  // Position of the element that follows the one currently presented.
  always_comb begin
    r_step = r_q;
    c_step = c_q;
    k_step = k_q + 1'b1;
    if (COL_MAJOR) begin
      if (r_q == R_LAST) begin
        r_step = '0;
        c_step = c_q + 1'b1;
      end else begin
        r_step = r_q + 1'b1;
      end
    end else begin
      if (c_q == C_LAST) begin
        c_step = '0;
        r_step = r_q + 1'b1;
      end else begin
        c_step = c_q + 1'b1;
      end
    end
  end

  // Element mux over the buffer; written as a compare loop so the counter
  // widths never have to match the array bounds exactly.
  always_comb begin
    sel_word = '0;
    for (int ri = 0; ri < M; ri++) begin
      for (int ci = 0; ci < P; ci++) begin
        if (r_step == RW'(ri) && c_step == CW'(ci)) begin
          sel_word = buf_q[ri][ci];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    word_d    = word_q;
    last_d    = last_q;
    stb_d     = stb_q;
    mat_ack_d = mat_ack_q;

    case (state_q)
      GET_MAT: begin
        // Ack rises on the first edge out of reset and stays up while idle.
        mat_ack_d = 1'b1;
        stb_d     = 1'b0;
        if (input_mat_stb && mat_ack_q) begin
          buf_d     = input_mat;
          r_d       = '0;
          c_d       = '0;
          k_d       = '0;
          word_d    = input_mat[0][0];
          last_d    = (M * P == 1);
          stb_d     = 1'b1;
          mat_ack_d = 1'b0;
          state_d   = PUT_WORDS;
        end
      end
      PUT_WORDS: begin
        if (stb_q && output_word_ack) begin
          if (last_q) begin
            stb_d     = 1'b0;
            last_d    = 1'b0;
            mat_ack_d = 1'b1;
            state_d   = GET_MAT;
          end else begin
            r_d    = r_step;
            c_d    = c_step;
            k_d    = k_step;
            word_d = sel_word;
            last_d = (k_step == K_LAST);
          end
        end
      end
      default: state_d = GET_MAT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= GET_MAT;
      buf_q     <= '0;
      r_q       <= '0;
      c_q       <= '0;
      k_q       <= '0;
      word_q    <= '0;
      last_q    <= 1'b0;
      stb_q     <= 1'b0;
      mat_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      r_q       <= r_d;
      c_q       <= c_d;
      k_q       <= k_d;
      word_q    <= word_d;
      last_q    <= last_d;
      stb_q     <= stb_d;
      mat_ack_q <= mat_ack_d;
    end
  end

  assign input_mat_ack   = mat_ack_q;
  assign output_word     = word_q;
  assign output_index    = k_q;
  assign output_last     = last_q;
  assign output_word_stb = stb_q;

endmodule

// File: tb/tb_mat_serializer.sv
// tb_mat_serializer: directed bench for mat_serializer. A row-major and a
// column-major instance (both 2x3) share every input, so each stream is
// checked against its own hand-computed element order.
module tb_mat_serializer;

  logic                    clk;
  logic                    rst_n;
  logic [1:0][2:0][31:0]   mat;
  logic                    mat_stb;
  logic                    word_ack;

  logic        r_mack, r_last, r_stb;
  logic [31:0] r_word;
  logic [2:0]  r_idx;
  logic        c_mack, c_last, c_stb;
  logic [31:0] c_word;
  logic [2:0]  c_idx;

  int checks;
  int failures;

  mat_serializer #(.M(2), .P(3), .COL_MAJOR(1'b0)) u_row (
    .clk(clk), .rst(rst_n),
    .input_mat(mat), .input_mat_stb(mat_stb), .input_mat_ack(r_mack),
    .output_word(r_word), .output_index(r_idx), .output_last(r_last),
    .output_word_stb(r_stb), .output_word_ack(word_ack)
  );

  mat_serializer #(.M(2), .P(3), .COL_MAJOR(1'b1)) u_col (
    .clk(clk), .rst(rst_n),
    .input_mat(mat), .input_mat_stb(mat_stb), .input_mat_ack(c_mack),
    .output_word(c_word), .output_index(c_idx), .output_last(c_last),
    .output_word_stb(c_stb), .output_word_ack(word_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mat(input logic [31:0] e[6]);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        mat[r][c] = e[r*3 + c];
  endtask

  // Offer a matrix and wait (bounded) for the capture edge.
  task automatic send(input logic [31:0] e[6]);
    int n;
    load_mat(e);
    mat_stb = 1'b1;
    n = 0;
    while (!r_mack && n < 20) begin
      tick();
      n++;
    end
    check_val("cap_ready", {31'd0, r_mack}, 32'd1);
    tick();
    mat_stb = 1'b0;
    $display("capture row_word0=0x%08h col_word0=0x%08h", r_word, c_word);
  endtask

  // Consume n words; duty is the percent chance of ack per cycle.
  task automatic drain(input logic [31:0] er[6], input logic [31:0] ec[6],
                       input int n, input int duty);
    for (int k = 0; k < n; k++) begin
      int stalls;
      check_val("stb_row", {31'd0, r_stb}, 32'd1);
      check_val("stb_col", {31'd0, c_stb}, 32'd1);
      check_val("word_row", r_word, er[k]);
      check_val("word_col", c_word, ec[k]);
      check_val("idx_row", {29'd0, r_idx}, k);
      check_val("idx_col", {29'd0, c_idx}, k);
      check_val("last_row", {31'd0, r_last}, (k == 5) ? 32'd1 : 32'd0);
      check_val("last_col", {31'd0, c_last}, (k == 5) ? 32'd1 : 32'd0);
      check_val("mack_busy", {31'd0, r_mack}, 32'd0);
      $display("word k=%0d row=0x%08h col=0x%08h last=%0d", k, r_word, c_word, r_last);
      stalls = 0;
      forever begin
        word_ack = ($urandom_range(0, 99) < duty) || (stalls >= 50);
        tick();
        if (word_ack) break;
        stalls++;
        check_val("hold_row", r_word, er[k]);
        check_val("hold_col", c_word, ec[k]);
        check_val("hold_idx", {29'd0, r_idx}, k);
        check_val("hold_stb", {31'd0, r_stb}, 32'd1);
      end
    end
  endtask

  task automatic check_idle_after();
    check_val("end_stb_row", {31'd0, r_stb}, 32'd0);
    check_val("end_stb_col", {31'd0, c_stb}, 32'd0);
    check_val("end_last", {31'd0, r_last}, 32'd0);
    check_val("end_mack_row", {31'd0, r_mack}, 32'd1);
    check_val("end_mack_col", {31'd0, c_mack}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m1_r[6]  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    logic [31:0] m1_c[6]  = '{32'd1, 32'd4, 32'd2, 32'd5, 32'd3, 32'd6};
    logic [31:0] m2_r[6]  = '{32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12};
    logic [31:0] m2_c[6]  = '{32'd7, 32'd10, 32'd8, 32'd11, 32'd9, 32'd12};
    logic [31:0] mf[6]    = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    mat      = '0;
    mat_stb  = 1'b0;
    word_ack = 1'b0;

    // Reset then idle.
    repeat (3) tick();
    check_val("rst_mack", {31'd0, r_mack}, 32'd0);
    check_val("rst_stb", {31'd0, r_stb}, 32'd0);
    check_val("rst_last", {31'd0, r_last}, 32'd0);
    check_val("rst_word", r_word, 32'd0);
    check_val("rst_idx", {29'd0, r_idx}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rel_mack_pre", {31'd0, r_mack}, 32'd0);
    tick();
    check_val("rel_mack", {31'd0, r_mack}, 32'd1);
    check_val("rel_stb", {31'd0, r_stb}, 32'd0);
    $display("reset done");

    // Full-rate streams (row- and column-major side by side).
    word_ack = 1'b1;
    send(m1_r);
    drain(m1_r, m1_c, 6, 100);
    check_idle_after();

    // Backpressure at 40% ack duty.
    send(m1_r);
    drain(m1_r, m1_c, 6, 40);
    check_idle_after();

    // Input changes after capture are ignored; second matrix waits its turn.
    word_ack = 1'b1;
    send(m1_r);
    load_mat(mf);
    mat_stb = 1'b1;
    drain(m1_r, m1_c, 6, 100);
    check_idle_after();
    send(mf);
    drain(mf, mf, 6, 100);
    check_idle_after();

    // Reset in the middle of a stream.
    send(m1_r);
    drain(m1_r, m1_c, 3, 100);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_stb", {31'd0, r_stb}, 32'd0);
    check_val("mid_rst_word", r_word, 32'd0);
    check_val("mid_rst_idx", {29'd0, r_idx}, 32'd0);
    check_val("mid_rst_mack", {31'd0, r_mack}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("mid_rel_stb", {31'd0, r_stb}, 32'd0);
    send(m2_r);
    drain(m2_r, m2_c, 6, 100);
    check_idle_after();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
